// File: rtl/cpu_pkg.sv
// Shared encodings for the single-issue core: opcodes, sequencer states and opcode classes.
package cpu_pkg;

    localparam logic [5:0] OP_ALU_1 = 6'b100000;
    localparam logic [5:0] OP_ADDI  = 6'b101000;
    localparam logic [5:0] OP_ORI   = 6'b101100;
    localparam logic [5:0] OP_XORI  = 6'b101011;
    localparam logic [5:0] OP_MOVI  = 6'b100010;
    localparam logic [5:0] OP_LWI   = 6'b000010;
    localparam logic [5:0] OP_SWI   = 6'b001010;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    typedef enum logic [1:0] {
        CL_ALU     = 2'd0,
        CL_LOAD    = 2'd1,
        CL_STORE   = 2'd2,
        CL_ILLEGAL = 2'd3
    } op_class_e;

    function automatic op_class_e classify(input logic [5:0] opcode);
        case (opcode)
            OP_ALU_1, OP_ADDI, OP_ORI, OP_XORI, OP_MOVI: classify = CL_ALU;
            OP_LWI:                                      classify = CL_LOAD;
            OP_SWI:                                      classify = CL_STORE;
            default:                                     classify = CL_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/inst_sequencer_if.sv
// Sequencer <-> memories/datapath bundle: IM/DM strobes, PC, datapath enables, debug state.
interface inst_sequencer_if #(
    parameter int DataSize = 32,
    parameter int MemSize  = 10
);
    logic [DataSize-1:0] instruction;
    logic [MemSize-1:0]  PC;
    logic                IM_read;
    logic                IM_write;
    logic                IM_enable;
    logic                DM_read;
    logic                DM_write;
    logic                DM_enable;
    logic                ir_load;
    logic                alu_en;
    logic                reg_write;
    logic                wb_sel;
    logic [2:0]          state;
    logic                halt;

    modport master (
        input  instruction,
        output PC, IM_read, IM_write, IM_enable,
        output DM_read, DM_write, DM_enable,
        output ir_load, alu_en, reg_write, wb_sel, state, halt
    );

    modport slave (
        output instruction,
        input  PC, IM_read, IM_write, IM_enable,
        input  DM_read, DM_write, DM_enable,
        input  ir_load, alu_en, reg_write, wb_sel, state, halt
    );
endinterface

// File: rtl/inst_sequencer_opcode_classifier.sv
// Combinational decode of instruction[30:25] into an opcode class.
module opcode_classifier
    import cpu_pkg::*;
#(
    parameter int DataSize = 32
) (
    input  logic [DataSize-1:0] instruction,
    output op_class_e           op_class
);
    logic unused_bits;

    assign op_class    = classify(instruction[30:25]);
    assign unused_bits = ^{instruction[DataSize-1:31], instruction[24:0]};
endmodule

// File: rtl/inst_sequencer.sv
// Multi-cycle FETCH..WB control FSM with PC counter and DM latency counter.
// Build option ILLEGAL_TRAP_EN: illegal opcodes trap into HALT instead of being skipped.
module inst_sequencer
    import cpu_pkg::*;
#(
    parameter int DataSize = 32,
    parameter int MemSize  = 10,
    parameter int MEM_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    inst_sequencer_if.master  bus
);
    // state  | meaning
    // IDLE   | post-reset, one cycle before the first fetch
    // FETCH  | IM read of word PC
    // DECODE | IR load, opcode class registered
    // EXEC   | ALU / address calc, PC advances
    // MEM    | DM access held MEM_LAT cycles
    // WB     | regfile write (ALU or DM_out)
    // HALT   | illegal-opcode trap, left only by reset

    localparam int             CW   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0]  LAST = CW'(MEM_LAT - 1);

    logic [2:0]         state_q,   state_d;
    logic [MemSize-1:0] pc_q,      pc_d;
    op_class_e          class_q,   class_d;
    logic [CW-1:0]      mem_cnt_q, mem_cnt_d;
    op_class_e          dec_class;

    opcode_classifier #(.DataSize(DataSize)) u_classifier (
        .instruction (bus.instruction),
        .op_class    (dec_class)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        class_d   = class_q;
        mem_cnt_d = mem_cnt_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                class_d = dec_class;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                pc_d = pc_q + 1'b1;
                case (class_q)
                    CL_ALU:             state_d = ST_WB;
                    CL_LOAD, CL_STORE:  state_d = ST_MEM;
`ifdef ILLEGAL_TRAP_EN
                    default:            state_d = ST_HALT;
`else
                    default:            state_d = ST_FETCH;
`endif
                endcase
            end
            ST_MEM: begin
                if (mem_cnt_q == LAST) begin
                    mem_cnt_d = '0;
                    state_d   = (class_q == CL_LOAD) ? ST_WB : ST_FETCH;
                end else begin
                    mem_cnt_d = mem_cnt_q + 1'b1;
                end
            end
            ST_WB:     state_d = ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
            ST_HALT:   state_d = ST_HALT;
`endif
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            class_q   <= CL_ALU;
            mem_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            class_q   <= class_d;
            mem_cnt_q <= mem_cnt_d;
        end
    end

    // Outputs are pure state/class decodes so an async reset clears them immediately.
    assign bus.PC        = pc_q;
    assign bus.state     = state_q;
    assign bus.IM_read   = (state_q == ST_FETCH);
    assign bus.IM_enable = (state_q == ST_FETCH);
    assign bus.IM_write  = 1'b0;
    assign bus.ir_load   = (state_q == ST_DECODE);
    assign bus.alu_en    = (state_q == ST_EXEC) && (class_q != CL_ILLEGAL);
    assign bus.DM_enable = (state_q == ST_MEM);
    assign bus.DM_read   = (state_q == ST_MEM) && (class_q == CL_LOAD);
    assign bus.DM_write  = (state_q == ST_MEM) && (class_q == CL_STORE);
    assign bus.reg_write = (state_q == ST_WB);
    assign bus.wb_sel    = (state_q == ST_WB) && (class_q == CL_LOAD);
`ifdef ILLEGAL_TRAP_EN
    assign bus.halt      = (state_q == ST_HALT);
`else
    assign bus.halt      = 1'b0;
`endif
endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer (MEM_LAT=3); honours ILLEGAL_TRAP_EN for the illegal-opcode step.
module tb_inst_sequencer;
    import cpu_pkg::*;

    // strobe vector: IM_read IM_enable IM_write DM_read DM_write DM_enable ir_load alu_en reg_write wb_sel halt
    localparam logic [10:0] V_ZERO  = 11'b00000000000;
    localparam logic [10:0] V_FETCH = 11'b11000000000;
    localparam logic [10:0] V_DEC   = 11'b00000010000;
    localparam logic [10:0] V_EXEC  = 11'b00000001000;
    localparam logic [10:0] V_MRD   = 11'b00010100000;
    localparam logic [10:0] V_MWR   = 11'b00001100000;
    localparam logic [10:0] V_WB    = 11'b00000000100;
    localparam logic [10:0] V_WBL   = 11'b00000000110;
    localparam logic [10:0] V_HALT  = 11'b00000000001;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem [0:1023];
    int          tests = 0;
    int          fails = 0;

    inst_sequencer_if #(.DataSize(32), .MemSize(10)) bus ();

    inst_sequencer #(.DataSize(32), .MemSize(10), .MEM_LAT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.instruction = imem[bus.PC];

    function automatic logic [31:0] mk(input logic [5:0] op);
        mk = {1'b0, op, 25'h0000123};
    endfunction

    function logic [10:0] strobes();
        strobes = {bus.IM_read, bus.IM_enable, bus.IM_write, bus.DM_read, bus.DM_write,
                   bus.DM_enable, bus.ir_load, bus.alu_en, bus.reg_write, bus.wb_sel, bus.halt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [2:0] st, input logic [9:0] pc, input logic [10:0] sv);
        step();
        chk({tag, "_state"}, 32'(bus.state), 32'(st));
        chk({tag, "_pc"}, 32'(bus.PC), 32'(pc));
        chk({tag, "_strobes"}, 32'(strobes()), 32'(sv));
    endtask

    // Invariants sampled every cycle.
    always @(negedge clk) begin
        chk("inv_im_write", 32'(bus.IM_write), 32'd0);
        chk("inv_dm_excl", 32'(bus.DM_read & bus.DM_write), 32'd0);
        chk("inv_regw_wb", 32'(bus.reg_write & (bus.state != ST_WB)), 32'd0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = mk(OP_ALU_1);
        imem[0]    = mk(OP_MOVI);
        imem[1]    = mk(OP_ADDI);
        imem[2]    = mk(OP_ORI);
        imem[3]    = mk(OP_LWI);
        imem[4]    = mk(OP_SWI);
        imem[5]    = mk(OP_SWI);
        imem[1023] = mk(OP_XORI);

        // reset state
        step(); step(); step();
        chk("rst_state", 32'(bus.state), 32'(ST_IDLE));
        chk("rst_pc", 32'(bus.PC), 32'd0);
        chk("rst_strobes", 32'(strobes()), 32'(V_ZERO));
        @(negedge clk);
        reset = 1'b0;

        // MOVI / ADDI / ORI, 4 cycles each
        cyc("movi_f", ST_FETCH,  10'd0, V_FETCH);
        cyc("movi_d", ST_DECODE, 10'd0, V_DEC);
        cyc("movi_e", ST_EXEC,   10'd0, V_EXEC);
        cyc("movi_w", ST_WB,     10'd1, V_WB);
        cyc("addi_f", ST_FETCH,  10'd1, V_FETCH);
        cyc("addi_d", ST_DECODE, 10'd1, V_DEC);
        cyc("addi_e", ST_EXEC,   10'd1, V_EXEC);
        cyc("addi_w", ST_WB,     10'd2, V_WB);
        cyc("ori_f",  ST_FETCH,  10'd2, V_FETCH);
        cyc("ori_d",  ST_DECODE, 10'd2, V_DEC);
        cyc("ori_e",  ST_EXEC,   10'd2, V_EXEC);
        cyc("ori_w",  ST_WB,     10'd3, V_WB);

        // LWI: 7 cycles, 3 MEM reads, WB from DM
        cyc("lwi_f",  ST_FETCH,  10'd3, V_FETCH);
        cyc("lwi_d",  ST_DECODE, 10'd3, V_DEC);
        cyc("lwi_e",  ST_EXEC,   10'd3, V_EXEC);
        cyc("lwi_m0", ST_MEM,    10'd4, V_MRD);
        cyc("lwi_m1", ST_MEM,    10'd4, V_MRD);
        cyc("lwi_m2", ST_MEM,    10'd4, V_MRD);
        cyc("lwi_w",  ST_WB,     10'd4, V_WBL);

        // SWI: 3 MEM writes, straight back to FETCH
        cyc("swi_f",  ST_FETCH,  10'd4, V_FETCH);
        cyc("swi_d",  ST_DECODE, 10'd4, V_DEC);
        cyc("swi_e",  ST_EXEC,   10'd4, V_EXEC);
        cyc("swi_m0", ST_MEM,    10'd5, V_MWR);
        cyc("swi_m1", ST_MEM,    10'd5, V_MWR);
        cyc("swi_m2", ST_MEM,    10'd5, V_MWR);
        cyc("swi_nf", ST_FETCH,  10'd5, V_FETCH);

        // async reset in the middle of a store
        cyc("sw2_d",  ST_DECODE, 10'd5, V_DEC);
        cyc("sw2_e",  ST_EXEC,   10'd5, V_EXEC);
        cyc("sw2_m0", ST_MEM,    10'd6, V_MWR);
        reset = 1'b1;
        #1;
        chk("arst_dm_write", 32'(bus.DM_write), 32'd0);
        chk("arst_state", 32'(bus.state), 32'(ST_IDLE));
        chk("arst_pc", 32'(bus.PC), 32'd0);
        chk("arst_strobes", 32'(strobes()), 32'(V_ZERO));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc("rs_f", ST_FETCH,  10'd0, V_FETCH);
        cyc("rs_d", ST_DECODE, 10'd0, V_DEC);
        cyc("rs_e", ST_EXEC,   10'd0, V_EXEC);
        cyc("rs_w", ST_WB,     10'd1, V_WB);

        // run forward to the last IM word, then check wrap
        for (int i = 0; i < 6000; i++) begin
            if (bus.state == ST_FETCH && bus.PC == 10'h3FF) break;
            step();
        end
        chk("ff_state", 32'(bus.state), 32'(ST_FETCH));
        chk("ff_pc", 32'(bus.PC), 32'h3FF);
        cyc("wrap_d", ST_DECODE, 10'h3FF, V_DEC);
        cyc("wrap_e", ST_EXEC,   10'h3FF, V_EXEC);
        cyc("wrap_w", ST_WB,     10'h000, V_WB);
        cyc("wrap_f", ST_FETCH,  10'h000, V_FETCH);

        // illegal opcode at word 1
        imem[1] = mk(6'b111111);
        cyc("pre_d", ST_DECODE, 10'd0, V_DEC);
        cyc("pre_e", ST_EXEC,   10'd0, V_EXEC);
        cyc("pre_w", ST_WB,     10'd1, V_WB);
        cyc("ill_f", ST_FETCH,  10'd1, V_FETCH);
        cyc("ill_d", ST_DECODE, 10'd1, V_DEC);
        cyc("ill_e", ST_EXEC,   10'd1, V_ZERO);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++) cyc("halt", ST_HALT, 10'd2, V_HALT);
`else
        cyc("skip_f", ST_FETCH,  10'd2, V_FETCH);
        cyc("skip_d", ST_DECODE, 10'd2, V_DEC);
        cyc("skip_e", ST_EXEC,   10'd2, V_EXEC);
        cyc("skip_w", ST_WB,     10'd3, V_WB);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
